// File: rtl/seq_divide_pkg.sv
// Shared definitions for the iterative restoring divider: FSM state encoding
// and the helper that sizes the step counter from the quotient width.
package seq_divide_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_CALC = 1'b1
    } state_e;

    // Counter must hold the value WIDTH_N itself, hence the +1.
    function automatic int cnt_width(input int width_n);
        return $clog2(width_n + 1);
    endfunction

endpackage

// File: rtl/seq_divide_div_step.sv
// One combinational restoring-division step: shift in one dividend bit,
// trial-subtract the divisor, and emit the quotient bit.
module div_step #(
    parameter int WIDTH_D = 8
) (
    input  logic [WIDTH_D-1:0] rem_i,
    input  logic               bit_i,
    input  logic [WIDTH_D-1:0] divisor_i,
    output logic [WIDTH_D-1:0] rem_o,
    output logic               qbit_o
);

    logic [WIDTH_D:0]   trial;
    logic [WIDTH_D-1:0] diff;

    assign trial = {rem_i, bit_i};

    // The true difference is always below the divisor, so it fits in WIDTH_D
    // bits; a set trial MSB alone already guarantees trial >= divisor.
    assign diff   = trial[WIDTH_D-1:0] - divisor_i;
    assign qbit_o = trial[WIDTH_D] | (trial[WIDTH_D-1:0] >= divisor_i);
    assign rem_o  = qbit_o ? diff : trial[WIDTH_D-1:0];

endmodule

// File: rtl/seq_divide.sv
// Iterative restoring divider producing one quotient bit per clock, with a
// start/busy/done handshake and an explicit divide-by-zero flag.
module seq_divide
    import seq_divide_pkg::*;
#(
    parameter int WIDTH_N = 8,
    parameter int WIDTH_D = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH_N-1:0] numerator,
    input  logic [WIDTH_D-1:0] denominator,
    output logic               busy,
    output logic               done,
    output logic [WIDTH_N-1:0] quotient,
    output logic [WIDTH_D-1:0] remain,
    output logic               div_zero
);

    localparam int CNT_W = cnt_width(WIDTH_N);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH_N-1:0] shift_q, shift_d;
    logic [WIDTH_D-1:0] divisor_q, divisor_d;
    logic [WIDTH_D-1:0] rem_q, rem_d;
    logic [WIDTH_N-1:0] quotient_q, quotient_d;
    logic [WIDTH_D-1:0] remain_q, remain_d;
    logic               div_zero_q, div_zero_d;
    logic               done_q, done_d;

    logic [WIDTH_D-1:0] step_rem;
    logic               step_qbit;

    div_step #(
        .WIDTH_D (WIDTH_D)
    ) u_step (
        .rem_i     (rem_q),
        .bit_i     (shift_q[WIDTH_N-1]),
        .divisor_i (divisor_q),
        .rem_o     (step_rem),
        .qbit_o    (step_qbit)
    );

    always_comb begin
        // NOTE: every next-state signal gets its hold value first, so no path
        // through this block can leave one unassigned and infer a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        divisor_d  = divisor_q;
        rem_d      = rem_q;
        quotient_d = quotient_q;
        remain_d   = remain_q;
        div_zero_d = div_zero_q;
        done_d     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start && (denominator != '0)) begin
                    shift_d   = numerator;
                    divisor_d = denominator;
                    rem_d     = '0;
                    cnt_d     = CNT_W'(WIDTH_N);
                    state_d   = ST_CALC;
                end else if (start) begin
                    quotient_d = '1;
                    remain_d   = '0;
                    div_zero_d = 1'b1;
                    done_d     = 1'b1;
                end
            end
            ST_CALC: begin
                shift_d = {shift_q[WIDTH_N-2:0], step_qbit};
                rem_d   = step_rem;
                cnt_d   = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    quotient_d = {shift_q[WIDTH_N-2:0], step_qbit};
                    remain_d   = step_rem;
                    div_zero_d = 1'b0;
                    done_d     = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: the operand/shift registers are reset too, so an aborted operation
    // leaves no stale partial state visible to a debugger or the next request.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register sampling the
        // pre-edge values, independent of statement order.
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            shift_q    <= '0;
            divisor_q  <= '0;
            rem_q      <= '0;
            quotient_q <= '0;
            remain_q   <= '0;
            div_zero_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            divisor_q  <= divisor_d;
            rem_q      <= rem_d;
            quotient_q <= quotient_d;
            remain_q   <= remain_d;
            div_zero_q <= div_zero_d;
            done_q     <= done_d;
        end
    end

    assign busy     = (state_q == ST_CALC);
    assign done     = done_q;
    assign quotient = quotient_q;
    assign remain   = remain_q;
    assign div_zero = div_zero_q;

endmodule

// File: tb/tb_seq_divide.sv
// Scoreboard bench for seq_divide: default 8/8 instance plus a 16/4 instance,
// checked against plain integer division with an expected completion cycle.
module tb_seq_divide;

    typedef struct {
        longint unsigned q;
        longint unsigned r;
        bit              dz;
        int              cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    exp_t q_a[$];
    exp_t q_b[$];

    // Default-width instance.
    logic       start_a = 1'b0;
    logic [7:0] num_a = '0, den_a = '0;
    logic       busy_a, done_a, dz_a;
    logic [7:0] quot_a, rem_a;

    // Wide-numerator, narrow-divisor instance.
    logic        start_b = 1'b0;
    logic [15:0] num_b = '0;
    logic [3:0]  den_b = '0;
    logic        busy_b, done_b, dz_b;
    logic [15:0] quot_b;
    logic [3:0]  rem_b;

    seq_divide #(.WIDTH_N(8), .WIDTH_D(8)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .numerator(num_a), .denominator(den_a),
        .busy(busy_a), .done(done_a), .quotient(quot_a), .remain(rem_a), .div_zero(dz_a)
    );

    seq_divide #(.WIDTH_N(16), .WIDTH_D(4)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .numerator(num_b), .denominator(den_b),
        .busy(busy_b), .done(done_b), .quotient(quot_b), .remain(rem_b), .div_zero(dz_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        else
            n_pass++;
    endtask

    function automatic exp_t model(input longint unsigned n, input longint unsigned d,
                                   input int wn, input int issue_cyc);
        exp_t e;
        if (d == 0) begin
            e.q  = (64'd1 << wn) - 1;
            e.r  = 0;
            e.dz = 1'b1;
            e.cyc = issue_cyc + 1;
        end else begin
            e.q  = n / d;
            e.r  = n % d;
            e.dz = 1'b0;
            e.cyc = issue_cyc + 1 + wn;
        end
        return e;
    endfunction

    // Monitors: pop one expectation per done pulse.
    always @(negedge clk) begin
        exp_t e;
        if (done_a) begin
            if (q_a.size() == 0) check("a_unexpected_done", 1, 0);
            else begin
                e = q_a.pop_front();
                check("a_quotient", quot_a, e.q);
                check("a_remain", rem_a, e.r);
                check("a_div_zero", dz_a, e.dz);
                check("a_latency", cyc, e.cyc);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (done_b) begin
            if (q_b.size() == 0) check("b_unexpected_done", 1, 0);
            else begin
                e = q_b.pop_front();
                check("b_quotient", quot_b, e.q);
                check("b_remain", rem_b, e.r);
                check("b_div_zero", dz_b, e.dz);
                check("b_latency", cyc, e.cyc);
            end
        end
    end

    // Issue one start pulse; operands are scrambled right after acceptance.
    task automatic issue_a(input logic [7:0] n, input logic [7:0] d, input bit now);
        if (!now) @(negedge clk);
        num_a = n; den_a = d; start_a = 1'b1;
        q_a.push_back(model(n, d, 8, cyc));
        @(negedge clk);
        start_a = 1'b0;
        num_a = 8'($urandom); den_a = 8'($urandom);
    endtask

    task automatic issue_b(input logic [15:0] n, input logic [3:0] d);
        @(negedge clk);
        num_b = n; den_b = d; start_b = 1'b1;
        q_b.push_back(model(n, d, 16, cyc));
        @(negedge clk);
        start_b = 1'b0;
        num_b = 16'($urandom); den_b = 4'($urandom);
    endtask

    task automatic drain_a();
        for (int i = 0; i < 40 && q_a.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        check("a_drain_pending", q_a.size(), 0);
        q_a.delete();
    endtask

    task automatic drain_b();
        for (int i = 0; i < 40 && q_b.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        check("b_drain_pending", q_b.size(), 0);
        q_b.delete();
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_quotient", quot_a, 0);
        check("rst_remain", rem_a, 0);
        check("rst_div_zero", dz_a, 0);
        check("rst_b_busy", busy_b, 0);
        rst = 1'b0;

        // Basic latency and busy window.
        issue_a(8'd3, 8'd8, 0);
        for (int i = 0; i < 8; i++) begin
            check("a_busy_window", busy_a, 1);
            if (i < 7) @(negedge clk);
        end
        drain_a();

        issue_a(8'd11, 8'd8, 0);   drain_a();
        issue_a(8'd255, 8'd1, 0);  drain_a();
        issue_a(8'd255, 8'd255, 0); drain_a();

        // Divide by zero: one-cycle latency, busy never rises.
        issue_a(8'd200, 8'd0, 0);
        check("a_zero_busy", busy_a, 0);
        drain_a();
        issue_a(8'd9, 8'd2, 0);    drain_a();

        // Start while busy is ignored; start in the done cycle is accepted.
        issue_a(8'd100, 8'd7, 0);
        repeat (2) @(negedge clk);
        num_a = 8'd5; den_a = 8'd1; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        for (int i = 0; i < 40 && !done_a; i++) @(negedge clk);
        check("a_done_seen", done_a, 1);
        issue_a(8'd50, 8'd6, 1);
        drain_a();

        // Reset mid-calculation aborts without a done pulse.
        issue_a(8'd77, 8'd5, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", busy_a, 0);
        check("abort_done", done_a, 0);
        check("abort_quotient", quot_a, 0);
        check("abort_remain", rem_a, 0);
        check("abort_div_zero", dz_a, 0);
        rst = 1'b0;
        q_a.delete();
        repeat (12) @(negedge clk);
        issue_a(8'd77, 8'd5, 0);   drain_a();

        // Random sweep on the default instance.
        for (int i = 0; i < 100; i++) begin
            issue_a(8'($urandom), (i % 10 == 0) ? 8'd0 : 8'($urandom), 0);
            drain_a();
        end

        // Wide numerator, narrow divisor.
        issue_b(16'd1000, 4'd7);   drain_b();
        for (int i = 0; i < 1000; i++) begin
            issue_b(16'($urandom), 4'($urandom_range(0, 15)));
            drain_b();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
